uart_tx_drain: RTL and testbench
================================

# uart_tx_drain

Paced drain stage between the transmit FIFO and the UART transmitter. Pops one byte at a time from a first-word-fall-through FIFO and issues a one-cycle transmit strobe to the UART. Tracks the UART busy flag, falling back to fixed frame timing when busy is not observed. Inserts a guard gap after each byte, replacing ad-hoc inter-byte wait counters in the monitor and the CPU output path.

## Interface
- GUARD, 16'd104, idle cycles inserted after each byte completes (one bit time at 115200 baud / 12 MHz).
- TIMEOUT, 16'd16, cycles to wait for u_is_transmitting to rise after a strobe.
- FRAME_CYCLES, 16'd1042, blind frame duration; also the busy-stuck watchdog.
- CLK  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- enable  in  1  permits starting new bytes; level-sensitive.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO head byte; valid whenever fifo_empty is 0.
- fifo_read  out  1  one-cycle pop strobe.
- u_tx_byte  out  8  byte presented to the UART.
- u_transmit  out  1  one-cycle UART transmit strobe.
- u_is_transmitting  in  1  UART busy flag.
- busy  out  1  high in every state except IDLE.
- sent_count  out  16  bytes launched, modulo 2^16.
- no_ack  out  1  sticky; set when a WAIT_HI timeout occurs.

## Operation
- States: IDLE, WAIT_HI, WAIT_LO, BLIND, GAP. There is one 16-bit down-counter cnt.
- IDLE: when enable & ~fifo_empty & ~u_is_transmitting, in a single cycle:
  - set u_tx_byte<=fifo_data, fifo_read<=1, u_transmit<=1;
  - increment sent_count; set cnt<=TIMEOUT;
  - go to WAIT_HI.
- WAIT_HI:
  - If u_is_transmitting: cnt<=FRAME_CYCLES, go to WAIT_LO.
  - Else if cnt==0: no_ack<=1, cnt<=FRAME_CYCLES, go to BLIND.
  - Else decrement cnt.
- WAIT_LO:
  - If ~u_is_transmitting: cnt<=GUARD, go to GAP.
  - Else if cnt==0 (watchdog): cnt<=GUARD, go to GAP.
  - Else decrement cnt.
- BLIND: decrement cnt; at cnt==0 set cnt<=GUARD and go to GAP. u_is_transmitting is ignored here.
- GAP: decrement cnt; at cnt==0 go to IDLE.
- fifo_read and u_transmit default to 0 every cycle; each is high for exactly one cycle per byte.
- The FIFO is never sampled in the cycle after a pop, because the FSM has left IDLE. This gives the FIFO one cycle to update empty and data.
- Deasserting enable never aborts a byte in flight. The byte completes through GAP, then the FSM holds in IDLE.
- Empty FIFO: the FSM stays in IDLE and fifo_read is never asserted.
- sent_count wraps from 16'hFFFF to 0.
- GUARD=0 is legal: the GAP state lasts one cycle.

## Timing
- Reset (reset==0 at a clock edge) sets, on the next cycle:
  - state=IDLE, cnt=0;
  - fifo_read=0, u_transmit=0, u_tx_byte=8'h00;
  - busy=0, sent_count=0, no_ack=0.
- Reset mid-byte abandons the byte without issuing another strobe. The UART is reset separately.
- Latency: the IDLE condition true at edge n gives fifo_read, u_transmit and the u_tx_byte update visible after edge n+1.
- u_tx_byte is stable from the strobe until the next launch.
- Minimum spacing between consecutive u_transmit strobes, UART behaving: 1 (WAIT_HI) + busy duration + 1 + (GUARD+1) + 1 cycles.
- Blind path spacing, busy never rises: (TIMEOUT+1) + (FRAME_CYCLES+1) + (GUARD+1) + 1 cycles.
- busy is combinational from state (state != IDLE), so it has no extra latency.

## Structure
- Shared package holds:
  - the state encoding (3-bit localparams IDLE..GAP);
  - default constants UART_BIT_CYCLES=104 and UART_FRAME_CYCLES=1042, derived from 12 MHz and 115200 baud.
- Single flat module with no sub-modules. The down-counter is inline.
- The top level instantiates one uart_tx_drain between fifo_out and uart0.

## Test plan
Benches use GUARD=4, TIMEOUT=3, FRAME_CYCLES=20.
- Normal path: FIFO holds 8'hA5 and the UART model raises busy 1 cycle after the strobe for 10 cycles. Required: one fifo_read and one u_transmit with u_tx_byte=8'hA5, sent_count=1, no_ack=0, and busy returning low 17 cycles after the strobe.
- Back-to-back: FIFO holds 8'h01, 8'h02, 8'h03. Required: three strobes in order, equal spacing, never two strobes while u_is_transmitting=1, sent_count=3.
- No-ack: busy is held 0 throughout and FIFO holds 8'h55. Required: a single strobe, no_ack=1 exactly 4 cycles after the strobe, and the next strobe no earlier than 4+21+5+1 cycles after the first.
- Stuck busy: busy rises and never falls. Required: the WAIT_LO watchdog exits after 21 cycles, GAP runs, and the next byte is launched only once busy drops (the IDLE guard).
- Enable/reset: drop enable mid-WAIT_LO. Required: the byte completes, then no further pops. Then assert reset low for 1 cycle during GAP. Required: all outputs return to reset values the next cycle and sent_count=0.
- Wrap: preload by driving 65536 launches, or use a force in simulation. Required: sent_count goes 16'hFFFF→16'h0000 on the next launch.

Source files
------------

// File: rtl/uart_tx_drain_pkg.sv
// uart_tx_drain_pkg: state encoding and UART timing defaults shared by the TX drain stage.
package uart_tx_drain_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        WAIT_LO = 3'd2,
        BLIND   = 3'd3,
        GAP     = 3'd4
    } state_t;

    // 12 MHz / 115200 baud; a 10-bit frame is ten bit times
    localparam logic [15:0] UART_BIT_CYCLES   = 16'd104;
    localparam logic [15:0] UART_FRAME_CYCLES = 16'd1042;

endpackage

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops one FIFO byte per launch, strobes the UART, waits out its busy flag
// (or a blind frame time if busy never rises), then inserts a guard gap before the next byte.
module uart_tx_drain
    import uart_tx_drain_pkg::*;
#(
    parameter logic [15:0] GUARD        = UART_BIT_CYCLES,
    parameter logic [15:0] TIMEOUT      = 16'd16,
    parameter logic [15:0] FRAME_CYCLES = UART_FRAME_CYCLES
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read,
    output logic [7:0]  u_tx_byte,
    output logic        u_transmit,
    input  logic        u_is_transmitting,
    output logic        busy,
    output logic [15:0] sent_count,
    output logic        no_ack
);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        start, set_no_ack, cnt_zero;

    assign cnt_zero = cnt == 16'd0;
    assign busy     = state != IDLE;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        start      = 1'b0;
        set_no_ack = 1'b0;
        case (state)
            IDLE: begin
                start = enable & ~fifo_empty & ~u_is_transmitting;
                if (start) begin
                    state_n = WAIT_HI;
                    cnt_n   = TIMEOUT;
                end
            end
            WAIT_HI: begin
                if (u_is_transmitting) begin
                    state_n = WAIT_LO;
                    cnt_n   = FRAME_CYCLES;
                end else if (cnt_zero) begin
                    // UART never acknowledged: fall back to fixed frame timing
                    state_n    = BLIND;
                    cnt_n      = FRAME_CYCLES;
                    set_no_ack = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            WAIT_LO: begin
                if (~u_is_transmitting || cnt_zero) begin
                    state_n = GAP;
                    cnt_n   = GUARD;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            BLIND: begin
                state_n = cnt_zero ? GAP : BLIND;
                cnt_n   = cnt_zero ? GUARD : cnt - 16'd1;
            end
            GAP: begin
                state_n = cnt_zero ? IDLE : GAP;
                cnt_n   = cnt_zero ? cnt : cnt - 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fifo_read  <= 1'b0;
            u_transmit <= 1'b0;
            u_tx_byte  <= '0;
            sent_count <= '0;
            no_ack     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            fifo_read  <= start;
            u_transmit <= start;
            if (start) begin
                u_tx_byte  <= fifo_data;
                sent_count <= sent_count + 16'd1;
            end
            if (set_no_ack)
                no_ack <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: table-driven single-byte scenarios, hand-written corner sequences and a
// randomized multi-byte run against an arithmetic model of strobe timing.
module tb_uart_tx_drain;

    localparam int G = 4, T = 3, F = 20;
    localparam int NEVER = 1 << 30;

    logic        CLK = 1'b0, reset = 1'b0, enable = 1'b0;
    logic        fifo_empty = 1'b1, u_is_transmitting = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_read, u_transmit, busy, no_ack;
    logic [7:0]  u_tx_byte;
    logic [15:0] sent_count;

    uart_tx_drain #(.GUARD(16'd4), .TIMEOUT(16'd3), .FRAME_CYCLES(16'd20)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read(fifo_read), .u_tx_byte(u_tx_byte),
        .u_transmit(u_transmit), .u_is_transmitting(u_is_transmitting), .busy(busy),
        .sent_count(sent_count), .no_ack(no_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        int d;
        int l;
        int off;
        int nack;
    } vec_t;

    vec_t       tv[7];
    int         n_chk = 0, n_fail = 0, cyc = 0, pops = 0;
    int         t = NEVER, ub_d = 0, ub_l = 0;
    logic [7:0] q[$], eb[$], bytes[$];
    int         strobes[$], rq_d[$], rq_l[$], ed[$], el[$], es[$];
    int         c0, k, s, s2, c, sm, idle, dd, ll, n;
    bit         ack, exp_nack;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO head and UART busy model: busy for ub_l cycles starting ub_d cycles after a strobe
    task automatic drive();
        fifo_empty        = q.size() == 0;
        fifo_data         = q.size() != 0 ? q[0] : 8'h00;
        u_is_transmitting = t >= ub_d && t < ub_d + ub_l;
    endtask

    task automatic step();
        logic pend, prev;
        pend = fifo_read;
        prev = u_is_transmitting;
        @(posedge CLK);
        #1;
        cyc++;
        if (pend === 1'b1) begin
            pops++;
            if (q.size() != 0) q.delete(0);
        end
        if (u_transmit === 1'b1) begin
            chk("strobe_while_busy", int'(prev), 0);
            strobes.push_back(cyc);
            bytes.push_back(u_tx_byte);
            t = 0;
            if (rq_d.size() != 0) begin
                ub_d = rq_d.pop_front();
                ub_l = rq_l.pop_front();
            end
        end else if (t < NEVER) t++;
        drive();
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        q.delete(); rq_d.delete(); rq_l.delete();
        ub_d = 0; ub_l = 0; t = NEVER;
        drive();
        step();
        reset = 1'b1;
        pops = 0;
        strobes.delete(); bytes.delete();
        drive();
    endtask

    task automatic wait_strobes(input int cnt, input int budget);
        int j;
        j = 0;
        while (strobes.size() < cnt && j < budget) begin
            step();
            j++;
        end
        chk("strobe_count", strobes.size(), cnt);
    endtask

    function automatic int st(input int i);
        return i < strobes.size() ? strobes[i] : -1;
    endfunction

    function automatic int by(input int i);
        return i < bytes.size() ? int'(bytes[i]) : -1;
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_fifo_read", int'(fifo_read), 0);
        chk("rst_u_transmit", int'(u_transmit), 0);
        chk("rst_u_tx_byte", int'(u_tx_byte), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sent_count", int'(sent_count), 0);
        chk("rst_no_ack", int'(no_ack), 0);
    endtask

    initial begin
        // {byte, busy delay, busy length, strobe-to-idle cycles, no_ack}
        tv[0] = '{8'hA5, 1, 10, 17, 0};
        tv[1] = '{8'h55, 0,  0, 30, 1};
        tv[2] = '{8'h3C, 3,  5, 14, 0};
        tv[3] = '{8'hC3, 4,  5, 30, 1};
        tv[4] = '{8'h7E, 1, 30, 28, 0};
        tv[5] = '{8'h0F, 2, 21, 29, 0};
        tv[6] = '{8'h81, 0,  1,  7, 0};

        do_reset();
        chk_reset_outputs();

        // empty FIFO: nothing launches
        enable = 1'b1;
        drive();
        repeat (10) step();
        chk("empty_pops", pops, 0);
        chk("empty_busy", int'(busy), 0);
        chk("empty_strobes", strobes.size(), 0);

        foreach (tv[i]) begin
            do_reset();
            q.push_back(tv[i].b);
            ub_d = tv[i].d;
            ub_l = tv[i].l;
            enable = 1'b1;
            drive();
            c0 = cyc;
            wait_strobes(1, 5);
            chk("launch_latency", st(0) - c0, 1);
            chk("tx_byte", int'(u_tx_byte), int'(tv[i].b));
            chk("sent_count", int'(sent_count), 1);
            k = 0;
            while (busy && k < 80) begin
                step();
                k++;
            end
            chk("busy_low_offset", cyc - st(0), tv[i].off);
            chk("no_ack", int'(no_ack), tv[i].nack);
            chk("pops", pops, 1);
        end

        // no-ack timing and blind-path spacing
        do_reset();
        q = '{8'h55, 8'h66};
        enable = 1'b1;
        drive();
        wait_strobes(1, 5);
        s = st(0);
        step_to(s + 3);
        chk("no_ack_early", int'(no_ack), 0);
        step();
        chk("no_ack_at_4", int'(no_ack), 1);
        wait_strobes(2, 60);
        chk("blind_spacing", st(1) - st(0), 4 + 21 + 5 + 1);
        chk("blind_byte2", by(1), 8'h66);

        // back-to-back with a well-behaved UART
        do_reset();
        q = '{8'h01, 8'h02, 8'h03};
        ub_d = 1; ub_l = 10;
        enable = 1'b1;
        drive();
        wait_strobes(3, 100);
        chk("b2b_byte0", by(0), 8'h01);
        chk("b2b_byte1", by(1), 8'h02);
        chk("b2b_byte2", by(2), 8'h03);
        chk("b2b_space01", st(1) - st(0), 18);
        chk("b2b_space12", st(2) - st(1), 18);
        chk("b2b_sent", int'(sent_count), 3);

        // stuck busy: watchdog exits, but next launch waits for busy to drop
        do_reset();
        q = '{8'hAA, 8'hBB};
        ub_d = 1; ub_l = 100000;
        enable = 1'b1;
        drive();
        wait_strobes(1, 5);
        s = st(0);
        step_to(s + 27);
        chk("stuck_gap_busy", int'(busy), 1);
        step();
        chk("stuck_idle", int'(busy), 0);
        step_to(s + 40);
        chk("stuck_held", strobes.size(), 1);
        ub_l = 0;
        drive();
        c = cyc;
        wait_strobes(2, 5);
        chk("stuck_release", st(1) - c, 1);
        chk("stuck_byte2", by(1), 8'hBB);

        // enable drop mid-byte, then reset during GAP
        do_reset();
        q = '{8'h11, 8'h22};
        ub_d = 1; ub_l = 10;
        enable = 1'b1;
        drive();
        wait_strobes(1, 5);
        s = st(0);
        step_to(s + 5);
        enable = 1'b0;
        step_to(s + 17);
        chk("en_byte_done", int'(busy), 0);
        step_to(s + 57);
        chk("en_no_pop", pops, 1);
        chk("en_no_strobe", strobes.size(), 1);
        enable = 1'b1;
        drive();
        wait_strobes(2, 5);
        s2 = st(1);
        step_to(s2 + 13);
        chk("gap_busy", int'(busy), 1);
        reset = 1'b0;
        step();
        chk_reset_outputs();
        reset = 1'b1;
        step();
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_strobes", strobes.size(), 2);

        // sent_count wrap
        do_reset();
        q.push_back(8'h9A);
        ub_d = 1; ub_l = 10;
        drive();
        force dut.sent_count = 16'hFFFF;
        step();
        step();
        release dut.sent_count;
        step();
        chk("wrap_preload", int'(sent_count), 16'hFFFF);
        enable = 1'b1;
        drive();
        wait_strobes(1, 5);
        chk("wrap_zero", int'(sent_count), 0);
        chk("wrap_byte", int'(u_tx_byte), 8'h9A);

        // randomized multi-byte run against the timing model
        do_reset();
        n = 12;
        eb.delete(); ed.delete(); el.delete(); es.delete();
        for (int i = 0; i < n; i++) begin
            q.push_back(8'($urandom));
            rq_d.push_back(int'($urandom_range(5, 0)));
            rq_l.push_back(int'($urandom_range(25, 0)));
        end
        eb = q; ed = rq_d; el = rq_l;
        enable = 1'b1;
        drive();
        sm = cyc + 1;
        exp_nack = 1'b0;
        for (int i = 0; i < n; i++) begin
            es.push_back(sm);
            dd = ed[i];
            ll = el[i];
            ack = ll > 0 && dd <= T;
            if (!ack) exp_nack = 1'b1;
            idle = ack ? sm + dd + (ll < F + 1 ? ll : F + 1) + G + 2 : sm + T + F + G + 3;
            c = (idle >= sm + dd && idle < sm + dd + ll) ? sm + dd + ll : idle;
            sm = c + 1;
        end
        wait_strobes(n, 1500);
        for (int i = 0; i < n; i++) begin
            chk("rand_time", st(i), es[i]);
            chk("rand_byte", by(i), int'(eb[i]));
        end
        chk("rand_sent", int'(sent_count), n);
        chk("rand_no_ack", int'(no_ack), int'(exp_nack));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
